cas_sequencer: RTL and testbench

CAS_SEQUENCER -- requirements
Module: cas_sequencer

---
 rtl/cas_sequencer_if.sv | 33 +++
 rtl/cas_sequencer.sv | 143 ++++++++++++++
 tb/tb_cas_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cas_sequencer_if.sv
// CPU/video DRAM strobe bus between the system side and cas_sequencer.
// Master drives the request side; slave drives the DRAM strobes.
interface cas_sequencer_if #(
  parameter int PH_W   = 4,
  parameter int N_BANK = 2
);
  localparam int BANK_W = $clog2(N_BANK);

  logic              PHASE_SYNC;
  logic              VID_EN;
  logic              MREQ_n;
  logic              RFSH_n;
  logic [BANK_W-1:0] BANK_SEL;
  logic              RAS_n;
  logic [N_BANK-1:0] CAS_n;
  logic              MUX;
  logic              READY;
  logic [PH_W-1:0]   PHASE;

  modport master (
    output PHASE_SYNC, VID_EN, MREQ_n,
    output RFSH_n, BANK_SEL,
    input  RAS_n, CAS_n, MUX,
    input  READY, PHASE
  );

  modport slave (
    input  PHASE_SYNC, VID_EN, MREQ_n,
    input  RFSH_n, BANK_SEL,
    output RAS_n, CAS_n, MUX,
    output READY, PHASE
  );
endinterface

// File: rtl/cas_sequencer.sv
// Slot-based DRAM RAS/CAS sequencer: video half-slot then CPU/refresh
// half-slot, strobes registered one clock behind the phase counter.
module cas_sequencer #(
  parameter int PH_W    = 4,
  parameter int N_BANK  = 2,
  parameter int VID_CAS = 2
) (
  input logic        CLK_n,
  input logic        RESET_n,
  cas_sequencer_if.slave bus
);
  localparam int H      = 2 ** (PH_W - 1);
  localparam int BANK_W = $clog2(N_BANK);
  localparam int LW     = PH_W - 1;

  localparam logic [LW-1:0] L_RAS0 = LW'(1);
  localparam logic [LW-1:0] L_END  = LW'(H - 2);
  localparam logic [LW-1:0] L_MUX  = LW'(H / 4);
  localparam logic [LW-1:0] L_CAS  = LW'(H / 2);
  localparam logic [LW-1:0] L_PG0  = LW'(H / 4 + 1);
  localparam logic [LW-1:0] L_PG1  = LW'(H / 2 - 1);
  localparam logic [LW-1:0] L_PG2  = LW'(H / 2 + 1);

  logic [PH_W-1:0]   phase_q, phase_d;
  logic              ras_q, ras_d;
  logic [N_BANK-1:0] cas_q, cas_d;
  logic              mux_q, mux_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              vid_q, vid_d;
  logic              cpu_q, cpu_d;
  logic              rf_q, rf_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  logic [LW-1:0] lo;
  logic          hi;
  logic          at_h;
  logic          accept;
  logic          in_ras;
  logic          in_mux;
  logic          in_cas;
  logic          in_vcas;

  always_comb begin
    lo      = phase_q[LW-1:0];
    hi      = phase_q[PH_W-1];
    at_h    = (phase_q == PH_W'(H));
    accept  = at_h && !bus.MREQ_n && !done_q
            && !bus.PHASE_SYNC;
    in_ras  = (lo >= L_RAS0) && (lo <= L_END);
    in_mux  = (lo >= L_MUX) && (lo <= L_END);
    in_cas  = (lo >= L_CAS) && (lo <= L_END);
    in_vcas = in_cas;
    if (VID_CAS == 2) begin
      in_vcas = ((lo >= L_PG0) && (lo <= L_PG1))
             || ((lo >= L_PG2) && (lo <= L_END));
    end

    phase_d = phase_q + 1'b1;
    ras_d   = 1'b1;
    cas_d   = '1;
    mux_d   = 1'b0;

    if (!hi && vid_q) begin
      if (in_ras)  ras_d    = 1'b0;
      if (in_mux)  mux_d    = 1'b1;
      if (in_vcas) cas_d[0] = 1'b0;
    end
    if (hi && (cpu_q || rf_q) && in_ras) begin
      ras_d = 1'b0;
    end
    if (hi && cpu_q) begin
      if (in_mux) mux_d         = 1'b1;
      if (in_cas) cas_d[bank_q] = 1'b0;
    end

    vid_d  = (phase_q == '0) ? bus.VID_EN : vid_q;
    cpu_d  = cpu_q;
    rf_d   = rf_q;
    bank_d = bank_q;
    if (at_h) begin
      cpu_d  = accept && bus.RFSH_n;
      rf_d   = accept && !bus.RFSH_n;
      bank_d = bus.BANK_SEL;
    end

    // done blocks re-issue until the CPU drops MREQ_n
    done_d = done_q;
    if (bus.MREQ_n) done_d = 1'b0;
    if (accept)     done_d = 1'b1;

    ready_d = ready_q;
    if (bus.MREQ_n) begin
      ready_d = 1'b1;
    end else if (!done_q) begin
      ready_d = at_h;
    end

    if (bus.PHASE_SYNC) begin
      phase_d = '0;
      ras_d   = 1'b1;
      cas_d   = '1;
      mux_d   = 1'b0;
      vid_d   = 1'b0;
      cpu_d   = 1'b0;
      rf_d    = 1'b0;
      done_d  = 1'b0;
      ready_d = bus.MREQ_n;
    end
  end

  always_ff @(posedge CLK_n) begin
    if (!RESET_n) begin
      phase_q <= '0;
      ras_q   <= 1'b1;
      cas_q   <= '1;
      mux_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      vid_q   <= 1'b0;
      cpu_q   <= 1'b0;
      rf_q    <= 1'b0;
      bank_q  <= '0;
    end else begin
      phase_q <= phase_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      mux_q   <= mux_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      vid_q   <= vid_d;
      cpu_q   <= cpu_d;
      rf_q    <= rf_d;
      bank_q  <= bank_d;
    end
  end

  assign bus.PHASE = phase_q;
  assign bus.RAS_n = ras_q;
  assign bus.CAS_n = cas_q;
  assign bus.MUX   = mux_q;
  assign bus.READY = ready_q;
endmodule

// File: tb/tb_cas_sequencer.sv
// Slot-level vectors for cas_sequencer (PH_W=4, H=8, N_BANK=2).
// Masks are indexed by the phase whose decode appears one clock later.
module tb_cas_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cas_sequencer_if bus ();

  cas_sequencer dut (
    .CLK_n  (clk),
    .RESET_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    bit          vid;
    int          mf;
    int          mt;
    bit          rf;
    bit          bs;
    logic [15:0] ras;
    logic [15:0] mux;
    logic [15:0] cas0;
    logic [15:0] cas1;
    logic [15:0] rdy;
    string       nm;
  } vec_t;

  typedef struct {
    logic       ras;
    logic [1:0] cas;
    logic       mux;
    logic       rdy;
    logic [3:0] ph;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(
    input logic rst, input logic sync,
    input logic vid, input logic mq,
    input logic rf, input logic bs,
    input logic e_ras, input logic [1:0] e_cas,
    input logic e_mux, input logic e_rdy,
    input logic [3:0] e_ph, input string nm);
    exp_t e;
    rst_n          = rst;
    bus.PHASE_SYNC = sync;
    bus.VID_EN     = vid;
    bus.MREQ_n     = mq;
    bus.RFSH_n     = rf;
    bus.BANK_SEL   = bs;
    sbq.push_back('{e_ras, e_cas, e_mux,
                    e_rdy, e_ph, nm});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.nm, " ras"}, {3'b0, bus.RAS_n}, {3'b0, e.ras});
    chk({e.nm, " cas"}, {2'b0, bus.CAS_n}, {2'b0, e.cas});
    chk({e.nm, " mux"}, {3'b0, bus.MUX}, {3'b0, e.mux});
    chk({e.nm, " rdy"}, {3'b0, bus.READY}, {3'b0, e.rdy});
    chk({e.nm, " ph"}, bus.PHASE, e.ph);
  endtask

  task automatic run_slot(input vec_t v,
                          input int last_p,
                          input bit sync_last);
    for (int p = 0; p <= last_p; p++) begin
      logic mq;
      mq = !(p >= v.mf && p <= v.mt);
      if (sync_last && p == last_p) begin
        cyc(1'b1, 1'b1, v.vid, mq, v.rf, v.bs,
            1'b1, 2'b11, 1'b0, mq, 4'd0,
            {v.nm, "/sync"});
      end else begin
        cyc(1'b1, 1'b0, v.vid, mq, v.rf, v.bs,
            !v.ras[p], {!v.cas1[p], !v.cas0[p]},
            v.mux[p], !v.rdy[p], 4'(p + 1),
            $sformatf("%s/p%0d", v.nm, p));
      end
    end
  endtask

  vec_t held1, held2, sa1, sa2, rm;

  initial begin
    tbl[0] = '{1'b0, 16, 16, 1'b1, 1'b0, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               "idle"};
    tbl[1] = '{1'b1, 16, 16, 1'b1, 1'b0, 16'h007E,
               16'h007C, 16'h0068, 16'h0000, 16'h0000,
               "video"};
    tbl[2] = '{1'b0, 2, 14, 1'b1, 1'b1, 16'h7E00,
               16'h7C00, 16'h0000, 16'h7000, 16'h00FC,
               "cpu_b1"};
    tbl[3] = '{1'b1, 2, 14, 1'b1, 1'b0, 16'h7E7E,
               16'h7C7C, 16'h7068, 16'h0000, 16'h00FC,
               "vid_cpu_b0"};
    tbl[4] = '{1'b0, 8, 14, 1'b0, 1'b1, 16'h7E00,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               "refresh"};
    tbl[5] = '{1'b0, 8, 14, 1'b1, 1'b1, 16'h7E00,
               16'h7C00, 16'h0000, 16'h7000, 16'h0000,
               "cpu_at_h"};
    tbl[6] = '{1'b0, 10, 14, 1'b1, 1'b0, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h7C00,
               "late_req"};
    held1 = '{1'b0, 2, 15, 1'b1, 1'b1, 16'h7E00,
              16'h7C00, 16'h0000, 16'h7000, 16'h00FC,
              "held1"};
    held2 = '{1'b0, 0, 14, 1'b1, 1'b1, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, 16'h0000,
              "held2"};
    sa1   = '{1'b0, 2, 15, 1'b1, 1'b1, 16'h7E00,
              16'h7C00, 16'h0000, 16'h7000, 16'h00FC,
              "sync1"};
    sa2   = '{1'b0, 0, 14, 1'b1, 1'b1, 16'h7E00,
              16'h7C00, 16'h0000, 16'h7000, 16'h00FF,
              "sync2"};
    rm    = '{1'b0, 2, 15, 1'b1, 1'b0, 16'h7E00,
              16'h7C00, 16'h7000, 16'h0000, 16'h00FC,
              "rst_mid"};

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b1, 2'b11, 1'b0, 1'b1, 4'd0, "reset0");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
        1'b1, 2'b11, 1'b0, 1'b1, 4'd0, "reset_sync");

    for (int i = 0; i < 7; i++) begin
      run_slot(tbl[i], 15, 1'b0);
    end

    run_slot(held1, 15, 1'b0);
    run_slot(held2, 15, 1'b0);

    run_slot(sa1, 11, 1'b1);
    run_slot(sa2, 15, 1'b0);

    run_slot(rm, 12, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b1, 2'b11, 1'b0, 1'b1, 4'd0, "rst_mid0");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b1, 2'b11, 1'b0, 1'b1, 4'd0, "rst_mid1");
    run_slot(tbl[0], 15, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
